btn_debounce: RTL and testbench

//  Conditions raw push-button inputs from the board for the LED controller.

---
 rtl/btn_debounce.sv | 118 +++++++++++
 tb/tb_btn_debounce.sv | 131 +++++++++++++
 2 files changed

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchroniser, then a debounce FSM per button.
// Outputs are a registered clean level plus one-cycle press/release pulses.
module btn_debounce #(
    parameter int NB_BTN     = 4,
    parameter int NB_CNT     = 20,
    parameter int DEB_CYCLES = 1000000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NB_BTN-1:0] i_btn,
    output logic [NB_BTN-1:0] o_btn,
    output logic [NB_BTN-1:0] o_press,
    output logic [NB_BTN-1:0] o_release
);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'(DEB_CYCLES - 1);

    logic [NB_BTN-1:0] sync_p0;
    logic [NB_BTN-1:0] sync_p1;

    state_t            state_q [NB_BTN];
    state_t            state_d [NB_BTN];
    logic [NB_CNT-1:0] cnt_q   [NB_BTN];
    logic [NB_CNT-1:0] cnt_d   [NB_BTN];
    logic [NB_BTN-1:0] btn_d;
    logic [NB_BTN-1:0] press_d;
    logic [NB_BTN-1:0] release_d;

    // Stage p0/p1: metastability chain; only sync_p1 feeds the FSMs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= i_btn;
            sync_p1 <= sync_p0;
        end
    end

    // FSM state, counters and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NB_BTN; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
            end
            o_btn     <= '0;
            o_press   <= '0;
            o_release <= '0;
        end else begin
            for (int i = 0; i < NB_BTN; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            o_btn     <= btn_d;
            o_press   <= press_d;
            o_release <= release_d;
        end
    end

    always_comb begin
        btn_d     = o_btn;
        press_d   = '0;
        release_d = '0;
        for (int i = 0; i < NB_BTN; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                IDLE: begin
                    if (sync_p1[i]) begin
                        state_d[i] = PRESS_WAIT;
                        cnt_d[i]   = '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!sync_p1[i]) begin
                        state_d[i] = IDLE;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        state_d[i] = PRESSED;
                        btn_d[i]   = 1'b1;
                        press_d[i] = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + NB_CNT'(1);
                    end
                end
                PRESSED: begin
                    if (!sync_p1[i]) begin
                        state_d[i] = RELEASE_WAIT;
                        cnt_d[i]   = '0;
                    end
                end
                RELEASE_WAIT: begin
                    // A bounce back to 1 returns to PRESSED with the level held high.
                    if (sync_p1[i]) begin
                        state_d[i] = PRESSED;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        state_d[i]   = IDLE;
                        btn_d[i]     = 1'b0;
                        release_d[i] = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + NB_CNT'(1);
                    end
                end
                default: begin
                    state_d[i] = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce with DEB_CYCLES=8: vector table of
// {reset, i_btn, hold cycles, expected outputs} plus a hand-written async-reset sequence.
module tb_btn_debounce;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] i_btn = 4'h0;
    logic [3:0] o_btn;
    logic [3:0] o_press;
    logic [3:0] o_release;

    int passed = 0;
    int total  = 0;

    btn_debounce #(
        .NB_BTN    (4),
        .NB_CNT    (4),
        .DEB_CYCLES(8)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .i_btn    (i_btn),
        .o_btn    (o_btn),
        .o_press  (o_press),
        .o_release(o_release)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       rst;
        logic [3:0] btn;
        int         n;
        logic [3:0] e_btn;
        logic [3:0] e_press;
        logic [3:0] e_rel;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic [3:0] btn, input int n,
                       input logic [3:0] eb, input logic [3:0] ep, input logic [3:0] er);
        vec_t v;
        v.rst = rst; v.btn = btn; v.n = n;
        v.e_btn = eb; v.e_press = ep; v.e_rel = er;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [11:0] got, input logic [11:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got btn/press/rel=%h/%h/%h, expected %h/%h/%h",
                      name, got[11:8], got[7:4], got[3:0], exp[11:8], exp[7:4], exp[3:0]);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        int cnt;

        // 1: reset held while inputs toggle
        for (int i = 0; i < 20; i++) add(1'b1, (i % 2 == 0) ? 4'hF : 4'h0, 1, 4'h0, 4'h0, 4'h0);
        add(1'b0, 4'h0, 3, 4'h0, 4'h0, 4'h0);
        // 2: bit0 held 30 cycles, press accepted after edge k+10
        add(1'b0, 4'h1, 10, 4'h0, 4'h0, 4'h0);
        add(1'b0, 4'h1, 1,  4'h1, 4'h1, 4'h0);
        add(1'b0, 4'h1, 19, 4'h1, 4'h0, 4'h0);
        // 3: 5-cycle glitch on bit2 rejected
        add(1'b0, 4'h5, 5,  4'h1, 4'h0, 4'h0);
        add(1'b0, 4'h1, 15, 4'h1, 4'h0, 4'h0);
        // 4: release bounce on bit0, then clean release
        add(1'b0, 4'h0, 3,  4'h1, 4'h0, 4'h0);
        add(1'b0, 4'h1, 2,  4'h1, 4'h0, 4'h0);
        add(1'b0, 4'h0, 10, 4'h1, 4'h0, 4'h0);
        add(1'b0, 4'h0, 1,  4'h0, 4'h0, 4'h1);
        add(1'b0, 4'h0, 5,  4'h0, 4'h0, 4'h0);
        // 5: simultaneous press and release on bits 1 and 3
        add(1'b0, 4'hA, 10, 4'h0, 4'h0, 4'h0);
        add(1'b0, 4'hA, 1,  4'hA, 4'hA, 4'h0);
        add(1'b0, 4'hA, 5,  4'hA, 4'h0, 4'h0);
        add(1'b0, 4'h0, 10, 4'hA, 4'h0, 4'h0);
        add(1'b0, 4'h0, 1,  4'h0, 4'h0, 4'hA);
        add(1'b0, 4'h0, 3,  4'h0, 4'h0, 4'h0);
        // 6: bit3 pressed, bit1 in PRESS_WAIT when reset hits; both re-debounced
        add(1'b0, 4'h8, 10, 4'h0, 4'h0, 4'h0);
        add(1'b0, 4'h8, 1,  4'h8, 4'h8, 4'h0);
        add(1'b0, 4'hA, 6,  4'h8, 4'h0, 4'h0);
        add(1'b1, 4'hA, 3,  4'h0, 4'h0, 4'h0);
        add(1'b0, 4'hA, 10, 4'h0, 4'h0, 4'h0);
        add(1'b0, 4'hA, 1,  4'hA, 4'hA, 4'h0);
        add(1'b0, 4'hA, 3,  4'hA, 4'h0, 4'h0);

        #1 reset = 1'b1;
        #1 check("reset_state", {o_btn, o_press, o_release}, 12'h000);

        for (int v = 0; v < vecs.size(); v++) begin
            reset = vecs[v].rst;
            i_btn = vecs[v].btn;
            for (int c = 0; c < vecs[v].n; c++) begin
                step();
                check($sformatf("vec%0d_cyc%0d", v, c), {o_btn, o_press, o_release},
                      {vecs[v].e_btn, vecs[v].e_press, vecs[v].e_rel});
            end
        end

        // Asynchronous reset mid-cycle clears outputs without a clock edge.
        #3 reset = 1'b1;
        #1 check("async_reset", {o_btn, o_press, o_release}, 12'h000);
        step();
        reset = 1'b0;
        i_btn = 4'h1;
        cnt = 0;
        while (o_press[0] !== 1'b1 && cnt < 30) begin
            step();
            cnt++;
        end
        total++;
        if (cnt == 11) passed++;
        else $display("FAIL press_latency: got %0d edges, expected 11", cnt);
        check("press_pulse", {o_btn, o_press, o_release}, 12'h110);
        step();
        check("press_cleared", {o_btn, o_press, o_release}, 12'h100);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
